// File: rtl/ram_dp_if.sv
// Port bundle for ram_dp: write/read port A, read-only port B and the busy flag.
// The master drives requests; the slave (the RAM) returns data and status.
interface ram_dp_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  busy;
  logic [WIDTH-1:0]      a_din;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_we;
  logic [WIDTH/8-1:0]    a_be;
  logic [WIDTH-1:0]      a_dout;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_re;
  logic [WIDTH-1:0]      b_dout;
  logic                  b_valid;

  modport master (
    output a_din, a_addr, a_we, a_be, b_addr, b_re,
    input  busy, a_dout, b_dout, b_valid
  );

  modport slave (
    input  a_din, a_addr, a_we, a_be, b_addr, b_re,
    output busy, a_dout, b_dout, b_valid
  );
endinterface

// File: rtl/ram_dp.sv
// Simple-dual-port RAM: port A read/write with byte enables, port B read-only.
// Selectable read latency and read-during-write policy, optional post-reset clear.
module ram_dp #(
  parameter int WIDTH          = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic     clk,
  input  logic     rst,
  ram_dp_if.slave  bus
);
  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  busy, acc_en, a_wr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [NB-1:0]         wr_mask;

  assign busy     = (state_q == CLEAR);
  assign acc_en   = ~rst & ~busy;
  assign a_wr     = acc_en & bus.a_we;
  assign bus.busy = busy;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The clear sequencer and port A share one write port into the array.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.a_addr;
    wr_data = bus.a_din;
    wr_mask = bus.a_be;
    if (busy && !rst) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      wr_data = '0;
      wr_mask = '1;
    end else if (a_wr) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (wr_mask[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_async
      assign bus.a_dout  = acc_en ? mem[bus.a_addr] : '0;
      assign bus.b_dout  = acc_en ? mem[bus.b_addr] : '0;
      assign bus.b_valid = bus.b_re & acc_en;
    end else begin : g_sync
      logic [WIDTH-1:0] old_a, merged, rd_a, rd_b;
      logic [WIDTH-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
      logic             b_valid_q, b_valid_d;

      assign old_a = mem[bus.a_addr];

      always_comb begin
        merged = old_a;
        for (int i = 0; i < NB; i++)
          if (bus.a_be[i]) merged[8*i +: 8] = bus.a_din[8*i +: 8];
      end

      // Array reads return the pre-edge word, so old-data mode needs no bypass.
      always_comb begin
        rd_a = old_a;
        rd_b = mem[bus.b_addr];
        if (RDW_MODE == 1 && a_wr) begin
          rd_a = merged;
          if (bus.b_addr == bus.a_addr) rd_b = merged;
        end
        a_dout_d  = busy ? '0 : rd_a;
        b_dout_d  = busy ? '0 : (bus.b_re ? rd_b : b_dout_q);
        b_valid_d = bus.b_re & ~busy;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_dout_q  <= '0;
          b_dout_q  <= '0;
          b_valid_q <= 1'b0;
        end else begin
          a_dout_q  <= a_dout_d;
          b_dout_q  <= b_dout_d;
          b_valid_q <= b_valid_d;
        end
      end

      assign bus.a_dout  = a_dout_q;
      assign bus.b_dout  = b_dout_q;
      assign bus.b_valid = b_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: four configurations driven with identical stimulus,
// a vector table for read/write/RDW behaviour plus hand sequences for clear and async reads.
module tb_ram_dp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_din  = '0;
  logic [3:0]  a_addr = '0;
  logic        a_we   = 1'b0;
  logic [1:0]  a_be   = '0;
  logic [3:0]  b_addr = '0;
  logic        b_re   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // if0: latency 1 / old data, if1: latency 1 / new data,
  // if2: latency 0, if3: latency 1 without clear
  ram_dp_if #(.WIDTH(16), .ADDR_WIDTH(4)) if0 (), if1 (), if2 (), if3 ();

  assign if0.a_din = a_din;  assign if1.a_din = a_din;  assign if2.a_din = a_din;  assign if3.a_din = a_din;
  assign if0.a_addr = a_addr; assign if1.a_addr = a_addr; assign if2.a_addr = a_addr; assign if3.a_addr = a_addr;
  assign if0.a_we = a_we;    assign if1.a_we = a_we;    assign if2.a_we = a_we;    assign if3.a_we = a_we;
  assign if0.a_be = a_be;    assign if1.a_be = a_be;    assign if2.a_be = a_be;    assign if3.a_be = a_be;
  assign if0.b_addr = b_addr; assign if1.b_addr = b_addr; assign if2.b_addr = b_addr; assign if3.b_addr = b_addr;
  assign if0.b_re = b_re;    assign if1.b_re = b_re;    assign if2.b_re = b_re;    assign if3.b_re = b_re;

  ram_dp #(.WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  ram_dp #(.WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  ram_dp #(.WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(0), .RDW_MODE(0), .CLEAR_ON_RESET(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  ram_dp #(.WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [3:0]  aa;
    logic [15:0] din;
    logic        re;
    logic [3:0]  ba;
    logic [15:0] ea0, ea1, eb0, eb1;
    logic        ebv;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (if0.busy && n < 40) begin
      // writes and reads during the clear must be ignored
      a_we = 1'b1; a_be = 2'b11; a_din = 16'hFFFF; a_addr = n[3:0];
      b_re = 1'b1; b_addr = n[3:0];
      #1;
      chk({name, "_bv_async_busy"}, {31'd0, if2.b_valid}, 32'd0);
      step();
      n++;
      chk({name, "_bv0_busy"}, {31'd0, if0.b_valid}, 32'd0);
      chk({name, "_bv1_busy"}, {31'd0, if1.b_valid}, 32'd0);
    end
    a_we = 1'b0; b_re = 1'b0;
    chk({name, "_busy_cycles"}, n, 32'd16);
  endtask

  initial begin
    vec[0] = '{1'b1, 2'b11, 4'd3,  16'hA5A5, 1'b1, 4'd3,  16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5, 1'b1};
    vec[1] = '{1'b1, 2'b01, 4'd3,  16'h00FF, 1'b0, 4'd3,  16'hA5A5, 16'hA5FF, 16'h0000, 16'hA5A5, 1'b0};
    vec[2] = '{1'b0, 2'b00, 4'd3,  16'h0000, 1'b1, 4'd3,  16'hA5FF, 16'hA5FF, 16'hA5FF, 16'hA5FF, 1'b1};
    vec[3] = '{1'b1, 2'b11, 4'd7,  16'h1111, 1'b0, 4'd0,  16'h0000, 16'h1111, 16'hA5FF, 16'hA5FF, 1'b0};
    vec[4] = '{1'b1, 2'b11, 4'd7,  16'h2222, 1'b1, 4'd7,  16'h1111, 16'h2222, 16'h1111, 16'h2222, 1'b1};
    vec[5] = '{1'b1, 2'b10, 4'd7,  16'hABCD, 1'b1, 4'd3,  16'h2222, 16'hAB22, 16'hA5FF, 16'hA5FF, 1'b1};
    vec[6] = '{1'b1, 2'b00, 4'd3,  16'hFFFF, 1'b1, 4'd7,  16'hA5FF, 16'hA5FF, 16'hAB22, 16'hAB22, 1'b1};
    vec[7] = '{1'b0, 2'b00, 4'd3,  16'h0000, 1'b1, 4'd3,  16'hA5FF, 16'hA5FF, 16'hA5FF, 16'hA5FF, 1'b1};
    vec[8] = '{1'b1, 2'b11, 4'd15, 16'hBEEF, 1'b1, 4'd15, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b1};
    vec[9] = '{1'b0, 2'b00, 4'd15, 16'h0000, 1'b0, 4'd15, 16'hBEEF, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0};

    // reset state
    step();
    chk("rst_busy0", {31'd0, if0.busy}, 32'd1);
    chk("rst_busy_noclr", {31'd0, if3.busy}, 32'd0);
    chk("rst_a_dout0", {16'd0, if0.a_dout}, 32'd0);
    chk("rst_b_dout0", {16'd0, if0.b_dout}, 32'd0);
    chk("rst_b_valid0", {31'd0, if0.b_valid}, 32'd0);
    chk("rst_a_dout_async", {16'd0, if2.a_dout}, 32'd0);
    chk("rst_a_dout_noclr", {16'd0, if3.a_dout}, 32'd0);
    rst = 1'b0;

    // reset again five cycles into the clear
    repeat (5) step();
    chk("mid_clear_busy", {31'd0, if0.busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("rerst_busy_noclr", {31'd0, if3.busy}, 32'd0);
    rst = 1'b0;
    count_clear("clr");
    chk("clr_done_busy1", {31'd0, if1.busy}, 32'd0);
    chk("clr_done_busy2", {31'd0, if2.busy}, 32'd0);

    // whole array reads zero after the clear
    for (int a = 0; a < 16; a++) begin
      a_addr = a[3:0]; b_addr = a[3:0]; b_re = 1'b1;
      step();
      chk($sformatf("zero_a_%0d", a), {16'd0, if0.a_dout}, 32'd0);
      chk($sformatf("zero_b_%0d", a), {16'd0, if0.b_dout}, 32'd0);
      chk($sformatf("zero_bv_%0d", a), {31'd0, if0.b_valid}, 32'd1);
      chk($sformatf("zero_async_%0d", a), {16'd0, if2.b_dout}, 32'd0);
    end
    b_re = 1'b0;

    // byte merge and read-during-write table
    for (int i = 0; i < 10; i++) begin
      a_we = vec[i].we; a_be = vec[i].be; a_addr = vec[i].aa; a_din = vec[i].din;
      b_re = vec[i].re; b_addr = vec[i].ba;
      step();
      chk($sformatf("v%0d_a_old", i), {16'd0, if0.a_dout}, {16'd0, vec[i].ea0});
      chk($sformatf("v%0d_a_new", i), {16'd0, if1.a_dout}, {16'd0, vec[i].ea1});
      chk($sformatf("v%0d_b_old", i), {16'd0, if0.b_dout}, {16'd0, vec[i].eb0});
      chk($sformatf("v%0d_b_new", i), {16'd0, if1.b_dout}, {16'd0, vec[i].eb1});
      chk($sformatf("v%0d_bv_old", i), {31'd0, if0.b_valid}, {31'd0, vec[i].ebv});
      chk($sformatf("v%0d_bv_new", i), {31'd0, if1.b_valid}, {31'd0, vec[i].ebv});
      if (i == 2) chk("noclr_merge", {16'd0, if3.b_dout}, 32'h0000A5FF);
    end
    a_we = 1'b0; b_re = 1'b0;

    // combinational read port follows the address with no clock edge
    b_addr = 4'd3;
    #1;
    chk("async_b_addr3", {16'd0, if2.b_dout}, 32'h0000A5FF);
    chk("async_bv_idle", {31'd0, if2.b_valid}, 32'd0);
    b_addr = 4'd7; b_re = 1'b1;
    #1;
    chk("async_b_addr7", {16'd0, if2.b_dout}, 32'h0000AB22);
    chk("async_bv_re", {31'd0, if2.b_valid}, 32'd1);
    b_re = 1'b0;
    a_addr = 4'd9; a_din = 16'h1234; a_be = 2'b11; a_we = 1'b1;
    #1;
    chk("async_a_prewrite", {16'd0, if2.a_dout}, 32'd0);
    step();
    a_we = 1'b0;
    #1;
    chk("async_a_postwrite", {16'd0, if2.a_dout}, 32'h00001234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
